skew_stream_buffer: RTL



---
 rtl/skew_stream_buffer_pkg.sv | 24 ++
 rtl/skew_stream_buffer_delay_line.sv | 69 ++++++
 rtl/skew_stream_buffer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/skew_stream_buffer_pkg.sv
// Shared types and constants for the skew/deskew column stream buffer.
// Holds the control-state encoding, mode encoding and lane-packing helpers.
package skew_stream_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    localparam logic MODE_SKEW   = 1'b0;
    localparam logic MODE_DESKEW = 1'b1;

    // Width of an index/counter that must hold values 0..n-1, never below 1 bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Total bits of a packed column of n lanes, w bits each.
    function automatic int unsigned lane_bits(input int unsigned n, input int unsigned w);
        return n * w;
    endfunction

endpackage

// File: rtl/skew_stream_buffer_delay_line.sv
// One lane of the buffer: N-1 shift stages of data/valid/last plus a tap mux
// feeding a registered output. Everything holds while i_en is low.
module skew_delay_line
    import skew_stream_buffer_pkg::*;
#(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    localparam int TAP_W     = idx_width(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_en,
    input  logic [TAP_W-1:0]      i_tap_sel,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    input  logic                  i_last,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_last
);

    localparam int STAGES = (N > 1) ? N - 1 : 1;

    logic [DATA_WIDTH-1:0] r_stg_data  [STAGES];
    logic                  r_stg_valid [STAGES];
    logic                  r_stg_last  [STAGES];

    logic [DATA_WIDTH-1:0] w_tap_data  [N];
    logic                  w_tap_valid [N];
    logic                  w_tap_last  [N];

    // Tap k is the lane input delayed by k enabled cycles; tap 0 is the live input.
    always_comb begin
        w_tap_data[0]  = i_data;
        w_tap_valid[0] = i_valid;
        w_tap_last[0]  = i_last;
        for (int k = 1; k < N; k++) begin
            w_tap_data[k]  = r_stg_data[k-1];
            w_tap_valid[k] = r_stg_valid[k-1];
            w_tap_last[k]  = r_stg_last[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                r_stg_data[k]  <= '0;
                r_stg_valid[k] <= 1'b0;
                r_stg_last[k]  <= 1'b0;
            end
            o_data  <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end else if (i_en) begin
            r_stg_data[0]  <= i_data;
            r_stg_valid[0] <= i_valid;
            r_stg_last[0]  <= i_last;
            for (int k = 1; k < STAGES; k++) begin
                r_stg_data[k]  <= r_stg_data[k-1];
                r_stg_valid[k] <= r_stg_valid[k-1];
                r_stg_last[k]  <= r_stg_last[k-1];
            end
            o_data  <= w_tap_data[i_tap_sel];
            o_valid <= w_tap_valid[i_tap_sel];
            o_last  <= w_tap_last[i_tap_sel] & w_tap_valid[i_tap_sel];
        end
    end

endmodule

// File: rtl/skew_stream_buffer.sv
// Column stream buffer: delays lane i by i beats (skew) or N-1-i beats (deskew),
// with per-lane valids, backpressure, and an automatic drain after each tile.
module skew_stream_buffer
    import skew_stream_buffer_pkg::*;
#(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] in_data,
    input  logic                    in_last,
    input  logic                    out_ready,
    output logic [N*DATA_WIDTH-1:0] out_data,
    output logic [N-1:0]            out_row_valid,
    output logic                    out_valid,
    output logic                    out_last,
    output state_e                  dbg_state
);

    localparam int CNT_W = idx_width(N);
    localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(N - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_mode_q;
    logic             w_mode_nxt;
    logic [CNT_W-1:0] r_drain_cnt;
    logic [CNT_W-1:0] w_drain_nxt;

    logic             w_adv;
    logic             w_accept;
    logic             w_mode_eff;
    logic [N-1:0]     w_lane_last;

    // Handshake: a beat transfers on a cycle where in_valid && in_ready; in_ready is
    // a function of out_ready and state only, never of in_valid, and a held beat stays put.
    assign w_adv    = out_ready;
    assign in_ready = out_ready && (r_state != DRAIN);
    assign w_accept = in_valid && in_ready;

    // The first beat of a tile must already see the mode it is about to latch.
    assign w_mode_eff = ((r_state == IDLE) && w_accept) ? mode : r_mode_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mode_q    <= MODE_SKEW;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mode_q    <= w_mode_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode_q;
        w_drain_nxt = r_drain_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_mode_nxt  = mode;
                    w_state_nxt = STREAM;
                    if (in_last) begin
                        w_state_nxt = (N > 1) ? DRAIN : IDLE;
                        w_drain_nxt = DRAIN_INIT;
                    end
                end
            end
            STREAM: begin
                if (w_accept && in_last) begin
                    w_state_nxt = (N > 1) ? DRAIN : IDLE;
                    w_drain_nxt = DRAIN_INIT;
                end
            end
            DRAIN: begin
                if (w_adv) begin
                    if (r_drain_cnt <= CNT_W'(1)) begin
                        w_state_nxt = IDLE;
                        w_drain_nxt = '0;
                    end else begin
                        w_drain_nxt = r_drain_cnt - CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        localparam logic [CNT_W-1:0] TAP_SKEW   = CNT_W'(gi);
        localparam logic [CNT_W-1:0] TAP_DESKEW = CNT_W'(N - 1 - gi);
        localparam logic             LAST_SKEW   = (gi == N - 1);
        localparam logic             LAST_DESKEW = (gi == 0);

        logic [CNT_W-1:0]      w_tap;
        logic [DATA_WIDTH-1:0] w_din;
        logic                  w_last_in;

        assign w_tap     = (w_mode_eff == MODE_DESKEW) ? TAP_DESKEW : TAP_SKEW;
        assign w_din     = w_accept ? in_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
        // The tile's last flag rides only the most-delayed lane.
        assign w_last_in = w_accept && in_last &&
                           ((w_mode_eff == MODE_DESKEW) ? LAST_DESKEW : LAST_SKEW);

        skew_delay_line #(
            .N          (N),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_line (
            .clk       (clk),
            .reset     (reset),
            .i_en      (w_adv),
            .i_tap_sel (w_tap),
            .i_data    (w_din),
            .i_valid   (w_accept),
            .i_last    (w_last_in),
            .o_data    (out_data[gi*DATA_WIDTH +: DATA_WIDTH]),
            .o_valid   (out_row_valid[gi]),
            .o_last    (w_lane_last[gi])
        );
    end

    assign out_valid = |out_row_valid;
    assign out_last  = |w_lane_last;
    assign dbg_state = r_state;

endmodule
